// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-select
// encoding and the controller FSM states.
package pipe_pkg;

  // Operand source selects for the ID-stage qa/qb muxes.
  localparam logic [1:0] FWD_REG = 2'd0;  // register file
  localparam logic [1:0] FWD_EXE = 2'd1;  // EXE ALU result
  localparam logic [1:0] FWD_MEM = 2'd2;  // MEM ALU result
  localparam logic [1:0] FWD_MDO = 2'd3;  // MEM load data

  typedef enum logic {
    RUN    = 1'b0,
    MCWAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one ID operand, resolved against the EXE and MEM
// write-back shadows. EXE wins over MEM; register 0 never forwards.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] r,
  input  logic       u,
  input  logic       ex_wreg,
  input  logic [4:0] ex_dest,
  input  logic       mem_wreg,
  input  logic       mem_m2reg,
  input  logic [4:0] mem_dest,
  output logic [1:0] sel
);

  // Priority compare: youngest producer first.
  always_comb begin
    sel = FWD_REG;
    if (u && (r != 5'd0)) begin
      if (ex_wreg && (ex_dest == r)) begin
        sel = FWD_EXE;
      end else if (mem_wreg && (mem_dest == r)) begin
        sel = mem_m2reg ? FWD_MDO : FWD_MEM;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks the write-back control of the EXE and
// MEM instructions, drives operand forwarding, load-use stalls and the
// multi-cycle EXE hold sequence.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MC_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic        usesRs,
  input  logic        usesRt,
  input  logic        wreg,
  input  logic        m2reg,
  input  logic [4:0]  destReg,
  input  logic        idMulti,
  output logic        stall,
  output logic        bubble,
  output logic        holdExe,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic [15:0] stallCount
);

  localparam int unsigned CntW = $clog2(MC_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MC_CYCLES - 1);
  localparam logic MultiEn = (MC_CYCLES > 1);

  hz_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     stall_count_q;

  logic       ex_wreg_q, ex_m2reg_q, ex_multi_q;
  logic [4:0] ex_dest_q;
  logic       mem_wreg_q, mem_m2reg_q;
  logic [4:0] mem_dest_q;

  logic load_use;

  fwd_sel u_fwd_a (
    .r         (rs),
    .u         (usesRs),
    .ex_wreg   (ex_wreg_q),
    .ex_dest   (ex_dest_q),
    .mem_wreg  (mem_wreg_q),
    .mem_m2reg (mem_m2reg_q),
    .mem_dest  (mem_dest_q),
    .sel       (fwda)
  );

  fwd_sel u_fwd_b (
    .r         (rt),
    .u         (usesRt),
    .ex_wreg   (ex_wreg_q),
    .ex_dest   (ex_dest_q),
    .mem_wreg  (mem_wreg_q),
    .mem_m2reg (mem_m2reg_q),
    .mem_dest  (mem_dest_q),
    .sel       (fwdb)
  );

  // A load in EXE feeding an ID operand: its data is not available until MEM.
  assign load_use = ex_wreg_q && ex_m2reg_q && ((fwda == FWD_EXE) || (fwdb == FWD_EXE));

  // FSM state and hold counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: enter MCWAIT when a multi-cycle op (not a load) is captured.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (MultiEn && !bubble && idMulti && !m2reg) begin
          state_d = MCWAIT;
          cnt_d   = CntLoad;
        end
      end
      MCWAIT: begin
        cnt_d = cnt_q - CntW'(1);
        // ex_multi_q is always set here; leaving on its absence is a safe exit.
        if ((cnt_q == CntW'(1)) || !ex_multi_q) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Pipeline control outputs; load-use is suppressed while EXE is held.
  always_comb begin
    stall   = 1'b0;
    bubble  = 1'b0;
    holdExe = 1'b0;
    unique case (state_q)
      RUN: begin
        stall  = load_use;
        bubble = load_use;
      end
      MCWAIT: begin
        stall   = 1'b1;
        holdExe = 1'b1;
      end
      default: ;
    endcase
  end

  // Shadow pipeline: EXE holds during MCWAIT while MEM drains a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_wreg_q   <= 1'b0;
      ex_m2reg_q  <= 1'b0;
      ex_dest_q   <= 5'd0;
      ex_multi_q  <= 1'b0;
      mem_wreg_q  <= 1'b0;
      mem_m2reg_q <= 1'b0;
      mem_dest_q  <= 5'd0;
    end else if (holdExe) begin
      mem_wreg_q  <= 1'b0;
      mem_m2reg_q <= 1'b0;
      mem_dest_q  <= 5'd0;
    end else begin
      mem_wreg_q  <= ex_wreg_q;
      mem_m2reg_q <= ex_m2reg_q;
      mem_dest_q  <= ex_dest_q;
      if (bubble) begin
        ex_wreg_q  <= 1'b0;
        ex_m2reg_q <= 1'b0;
        ex_dest_q  <= 5'd0;
        ex_multi_q <= 1'b0;
      end else begin
        ex_wreg_q  <= wreg;
        ex_m2reg_q <= m2reg;
        ex_dest_q  <= destReg;
        ex_multi_q <= idMulti & ~m2reg;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_q <= 16'd0;
    end else if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign stallCount = stall_count_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage CPU. It sequences the ID/EXE pipeline register and the stages around it. It keeps a shadow copy of the write-back control (wreg, m2reg, destReg) of the instructions in EXE and MEM, and from that copy it produces the operand-forwarding selects for qa/qb, load-use stalls with bubble injection, and multi-cycle EXE holds. It sits beside the ID stage and drives the PC/IF-ID write enable, the ID/EXE bubble and hold controls, and the ID-stage forwarding muxes.

## Interface
- MC_CYCLES, 4: EXE occupancy in cycles of an instruction flagged idMulti (≥1; 1 = no hold).
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rs  in  5  ID instruction source register A.
- rt  in  5  ID instruction source register B.
- usesRs  in  1  ID instruction reads rs.
- usesRt  in  1  ID instruction reads rt.
- wreg  in  1  ID instruction writes the register file.
- m2reg  in  1  ID instruction is a load.
- destReg  in  5  ID instruction destination register.
- idMulti  in  1  ID instruction needs the multi-cycle EXE unit.
- stall  out  1  freeze PC and IF/ID; active-high.
- bubble  out  1  force ID/EXE control (wreg, m2reg, wmem) to 0 this edge.
- holdExe  out  1  ID/EXE register keeps its contents this edge.
- fwda  out  2  qa select: 0 regfile, 1 EXE ALU result, 2 MEM ALU result, 3 MEM load data.
- fwdb  out  2  qb select, same encoding.
- stallCount  out  16  saturating count of cycles with stall=1.

## Operation
- Shadow state: exWreg/exM2reg/exDest, memWreg/memM2reg/memDest, plus exMulti.
- Edge update when holdExe=0: EXE ← (bubble ? zeros : ID inputs). In the same edge, MEM ← EXE.
- Edge update when holdExe=1: EXE holds. MEM ← zeros, because the bubble drains downstream.
- Forward (per operand r, used flag u): EXE match (exWreg & exDest==r & r≠0 & u) → 1. Otherwise MEM match → 2, or 3 when memM2reg. Otherwise 0.
  - EXE has priority over MEM.
  - Register 0 never forwards.
- Load-use: exWreg & exM2reg & EXE match on rs or rt → stall=1, bubble=1.
- FSM states:
  - RUN: load-use logic active. An ID instruction with idMulti=1 captured into EXE (holdExe=0, bubble=0) with MC_CYCLES>1 → load counter with MC_CYCLES−1 and go to MCWAIT.
  - MCWAIT: stall=1, holdExe=1, bubble=0. The counter decrements each cycle. At counter==1 the next state is RUN. Load-use is suppressed.
- Forwarding selects remain computed in MCWAIT. The values in the final MCWAIT cycle are the ones used.
- An instruction with idMulti=1 and m2reg=1 is treated as a load. idMulti is ignored.
- stallCount increments every cycle stall=1 and saturates at 0xFFFF.

## Timing
- Reset:
  - All shadow registers, the counter and stallCount are 0; the state is RUN.
  - Outputs are stall=0, bubble=0, holdExe=0, fwda=fwdb=0.
  - Reset asserted mid-MCWAIT aborts to RUN on the next edge.
- All outputs except stallCount are combinational from registered state plus the ID inputs. They are valid in the same cycle.
- Load-use stall lasts exactly 1 cycle. In the next cycle the load is in MEM, so the dependent operand selects 3.
- MCWAIT lasts exactly MC_CYCLES−1 cycles. A dependent ID instruction then sees fwd=1 in the final cycle.
- Back-to-back multi-cycle instructions each incur the full MCWAIT with no RUN gap beyond one cycle.
- stallCount updates on the edge following the stall cycle.

## Structure
- Package pipe_pkg holds:
  - fwd encoding constants FWD_REG=2'd0, FWD_EXE=2'd1, FWD_MEM=2'd2, FWD_MDO=2'd3.
  - the FSM state enum {RUN, MCWAIT}.
- Sub-module fwd_sel: combinational compare of one operand against the EXE/MEM shadows, producing a 2-bit select. It is instantiated for rs and rt.
- Counter width is $clog2(MC_CYCLES)+1.

## Test plan
- add $3 then sub $4,$3,$5 → fwda=1 in sub's ID cycle. Then or $6,$3,$0 next → fwda=2.
- lw $2 then add $7,$2,$2 → stall=1, bubble=1 for 1 cycle, then fwda=fwdb=3. stallCount=1.
- Writer to $0 followed by reader of $0 → fwda=0 and no stall.
- MC_CYCLES=4, multi-cycle op writing $8, then reader of $8 → stall=holdExe=1 for 3 cycles, the MEM shadow shows wreg=0, and fwda=1 in the last cycle.
- Reset asserted in the 2nd MCWAIT cycle → next cycle stall=0, holdExe=0, stallCount=0, and the state is RUN.
- Force 70000 stall cycles → stallCount holds at 0xFFFF.
